pbutton_event_arbiter: RTL and testbench
========================================

// Module: pbutton_event_arbiter
// PURPOSE
//  Sits between the pbutton_debouncer instances and their consumers (seg7 counters, later a CPU/UART logger).
//  Serialises per-button push/release pulses into one ordered event stream through a FIFO.
//  Arbitrates simultaneous events round-robin, so none is lost or silently overwritten.
//  Grants a single shared hold-time counter to exactly one button at a time.
// PARAMETERS
//  NB_BTN      4   number of debounced buttons (2..8)
//  FIFO_DEPTH  8   event FIFO entries, power of 2 (2..64)
//  CNT_W       32  width of hold timers and shared active counter
// PORTS
//  CLOCK_50      in   1           system clock, all logic on posedge
//  RESET         in   1           asynchronous, active-high reset
//  btn_active    in   NB_BTN      debounced level, 1 = button down
//  btn_pushed    in   NB_BTN      1-cycle push pulse per button
//  btn_released  in   NB_BTN      1-cycle release pulse per button
//  evt_valid     out  1           head-of-FIFO event present
//  evt_ready     in   1           consumer accepts event (pop when valid&&ready)
//  evt_btn       out  IDW         button index, IDW=$clog2(NB_BTN)
//  evt_type      out  1           1 = push, 0 = release
//  evt_time      out  CNT_W       release: hold cycles; push: 0
//  owner_valid   out  1           shared counter currently owned
//  owner_id      out  IDW         owning button index
//  active_cnt    out  CNT_W       shared hold counter of owner
//  overflow      out  1           sticky: an event was dropped
//  clr_overflow  in   1           synchronous clear of overflow
// BEHAVIOUR
//  Reset: every output 0; FIFO empty; pending bits 0; rr pointer 0; all timers 0.
//  Pending:
//   - push_pend[i]/rel_pend[i] set on the matching pulse.
//   - Pulse while the bit is already set -> overflow<=1, event dropped, bit stays 1.
//  Hold timer[i]:
//   - Loads 0 on btn_pushed[i]; +1 per cycle while btn_active[i]; saturates at all-ones.
//   - Release pulse latches timer[i] into rel_time[i].
//  Arbitration:
//   - Each cycle grant at most one button with any pending bit, round-robin from rr_ptr.
//   - rr_ptr <= grant+1 (mod NB_BTN) after a grant.
//   - Within a button, push is granted before release; release waits one more grant.
//   - Grant occurs only if the FIFO is not full OR a pop happens in the same cycle.
//   - Grant clears the pending bit and writes {btn,type,time}.
//   - A pulse arriving on the same cycle its bit is granted re-sets the bit; no overflow.
//  FIFO:
//   - Show-ahead; evt_* = head entry; evt_valid = !empty.
//   - Simultaneous push+pop is legal at any fill level, including full and empty.
//  Latency: pulse at edge t -> evt_valid high after edge t+1 (uncontended, FIFO empty).
//   - Back-to-back grants sustain 1 event/cycle.
//  Full FIFO with evt_ready=0: grants stall, pending bits hold; a further pulse on a held bit sets overflow.
//  Ownership:
//   - No owner and any btn_active -> lowest active index becomes owner; active_cnt<=0 on that edge.
//   - active_cnt +1 per cycle while btn_active[owner_id]; saturates.
//   - Owner goes inactive -> owner_valid<=0 next edge; active_cnt holds its value.
//   - Other buttons pressed while owned are ignored for ownership.
//  overflow: set has priority over clr_overflow on the same cycle.
//  RESET mid-operation: async clear of all state; events in flight are discarded.
// STRUCTURE
//  Shared include pbutton_defs.vh:
//   - EVT_PUSH=1'b1, EVT_RELEASE=1'b0
//   - event-word field offsets (BTN, TYPE, TIME)
//  Sub-module pbutton_evt_fifo: sync show-ahead FIFO with async reset.
//  Top holds pending regs, timers, RR arbiter and ownership FSM (IDLE/OWNED).
// TESTING
//  1 Single press on btn1, held 100 cycles, evt_ready=1:
//    -> push evt {1,1,0}, then release evt {1,0,100}; overflow=0.
//  2 Push pulses on btn0..3 same cycle, rr_ptr=2:
//    -> events in order btn 2,3,0,1 on 4 consecutive cycles.
//  3 evt_ready=0, 9 distinct events:
//    -> 8 queued; 9th held pending; a repeat pulse on it -> overflow=1.
//    -> Then evt_ready=1 drains all 9 in order.
//  4 btn2 active, then btn0 active 5 cycles later, btn2 held 40 cycles:
//    -> owner_id=2, active_cnt=40 held.
//    -> owner_valid drops; next press of btn0 takes ownership with active_cnt reset to 0.
//  5 RESET asserted mid-drain with 3 events queued:
//    -> evt_valid=0, active_cnt=0 immediately, no stale events after deassert.
//  6 Pop and grant on the same cycle with FIFO full:
//    -> count stays 8, no overflow, ordering preserved.

Source files
------------

// File: rtl/pbutton_event_arbiter_pkg.sv
// Shared definitions for the push-button event arbiter.
// Contents: event type codes, event-word layout, ownership FSM states.
package pbutton_event_arbiter_pkg;

    localparam logic EVT_PUSH    = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

    typedef enum logic {
        OWN_IDLE  = 1'b0,
        OWN_OWNED = 1'b1
    } own_state_t;

    // Event word, LSB first: time[CNT_W-1:0], type, btn[IDW-1:0]
    function automatic int unsigned evt_type_bit(input int unsigned cnt_w);
        return cnt_w;
    endfunction

    function automatic int unsigned evt_btn_lsb(input int unsigned cnt_w);
        return cnt_w + 1;
    endfunction

    function automatic int unsigned evt_word_w(input int unsigned cnt_w,
                                               input int unsigned idw);
        return cnt_w + 1 + idw;
    endfunction

    function automatic int unsigned rr_offset(input int unsigned base,
                                              input int unsigned k,
                                              input int unsigned n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/pbutton_evt_fifo.sv
// Synchronous show-ahead FIFO with asynchronous reset; the head entry is always visible on o_data.
// A push is accepted when full as long as a pop happens on the same edge.
module pbutton_evt_fifo #(
    parameter int unsigned  WIDTH = 35,
    parameter int unsigned  DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pbutton_event_arbiter.sv
// Serialises debounced push/release pulses into one ordered event FIFO (round-robin arbitration)
// and hands a single shared hold counter to one pressed button at a time.
module pbutton_event_arbiter
    import pbutton_event_arbiter_pkg::*;
#(
    parameter int unsigned  NB_BTN     = 4,
    parameter int unsigned  FIFO_DEPTH = 8,
    parameter int unsigned  CNT_W      = 32,
    localparam int unsigned IDW        = $clog2(NB_BTN)
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [NB_BTN-1:0] btn_active,
    input  logic [NB_BTN-1:0] btn_pushed,
    input  logic [NB_BTN-1:0] btn_released,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDW-1:0]    evt_btn,
    output logic              evt_type,
    output logic [CNT_W-1:0]  evt_time,
    output logic              owner_valid,
    output logic [IDW-1:0]    owner_id,
    output logic [CNT_W-1:0]  active_cnt,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam int unsigned      TYPE_BIT = evt_type_bit(CNT_W);
    localparam int unsigned      BTN_LSB  = evt_btn_lsb(CNT_W);
    localparam int unsigned      EVT_W    = evt_word_w(CNT_W, IDW);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [NB_BTN-1:0] r_push_pend;
    logic [NB_BTN-1:0] r_rel_pend;
    logic [CNT_W-1:0]  r_timer    [NB_BTN];
    logic [CNT_W-1:0]  r_rel_time [NB_BTN];
    logic [IDW-1:0]    r_rr_ptr;
    logic              r_overflow;
    own_state_t        r_own_state;
    own_state_t        w_own_next;
    logic [IDW-1:0]    r_owner_id;
    logic [CNT_W-1:0]  r_active_cnt;

    logic [NB_BTN-1:0] w_any_pend;
    logic [NB_BTN-1:0] w_clr_push;
    logic [NB_BTN-1:0] w_clr_rel;
    logic              w_gnt_found;
    logic [IDW-1:0]    w_gnt_idx;
    logic              w_gnt_is_push;
    logic              w_gnt_type;
    logic [CNT_W-1:0]  w_gnt_time;
    logic              w_grant;
    logic              w_pop;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [EVT_W-1:0]  w_evt_wdata;
    logic [EVT_W-1:0]  w_head;
    logic              w_ovf_set;
    logic              w_low_found;
    logic [IDW-1:0]    w_low_idx;
    logic              w_own_take;
    logic              w_own_inc;

    // ---------------- round-robin arbiter ----------------
    assign w_any_pend = r_push_pend | r_rel_pend;

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int unsigned k = 0; k < NB_BTN; k++) begin
            if (!w_gnt_found && w_any_pend[IDW'(rr_offset(32'(r_rr_ptr), k, NB_BTN))]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IDW'(rr_offset(32'(r_rr_ptr), k, NB_BTN));
            end
        end
    end

    // A pop frees a slot on the same edge, so a full FIFO can still take a grant.
    assign w_pop         = !w_fifo_empty && evt_ready;
    assign w_grant       = w_gnt_found && (!w_fifo_full || w_pop);
    assign w_gnt_is_push = r_push_pend[w_gnt_idx];
    assign w_gnt_type    = w_gnt_is_push ? EVT_PUSH : EVT_RELEASE;
    assign w_gnt_time    = w_gnt_is_push ? '0 : r_rel_time[w_gnt_idx];
    assign w_evt_wdata   = {w_gnt_idx, w_gnt_type, w_gnt_time};

    always_comb begin
        w_clr_push = '0;
        w_clr_rel  = '0;
        if (w_grant) begin
            if (w_gnt_is_push) begin
                w_clr_push[w_gnt_idx] = 1'b1;
            end else begin
                w_clr_rel[w_gnt_idx] = 1'b1;
            end
        end
    end

    // A pulse only drops when its bit is set and not being granted this edge.
    assign w_ovf_set = |((btn_pushed & r_push_pend & ~w_clr_push) |
                         (btn_released & r_rel_pend & ~w_clr_rel));

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_push_pend <= '0;
            r_rel_pend  <= '0;
            for (int unsigned i = 0; i < NB_BTN; i++) begin
                r_timer[i]    <= '0;
                r_rel_time[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NB_BTN; i++) begin
                if (btn_pushed[i]) begin
                    r_push_pend[i] <= 1'b1;
                end else if (w_clr_push[i]) begin
                    r_push_pend[i] <= 1'b0;
                end
                if (btn_released[i]) begin
                    r_rel_pend[i] <= 1'b1;
                end else if (w_clr_rel[i]) begin
                    r_rel_pend[i] <= 1'b0;
                end
                if (btn_released[i] && (!r_rel_pend[i] || w_clr_rel[i])) begin
                    r_rel_time[i] <= r_timer[i];
                end
                if (btn_pushed[i]) begin
                    r_timer[i] <= '0;
                end else if (btn_active[i] && (r_timer[i] != CNT_MAX)) begin
                    r_timer[i] <= r_timer[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_rr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= (w_gnt_idx == IDW'(NB_BTN - 1)) ? '0 : w_gnt_idx + IDW'(1);
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    pbutton_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLOCK_50),
        .i_rst   (RESET),
        .i_push  (w_grant),
        .i_pop   (w_pop),
        .i_data  (w_evt_wdata),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // ---------------- shared counter ownership ----------------
    always_comb begin
        w_low_found = 1'b0;
        w_low_idx   = '0;
        for (int unsigned i = NB_BTN; i > 0; i--) begin
            if (btn_active[i-1]) begin
                w_low_found = 1'b1;
                w_low_idx   = IDW'(i - 1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_own_state <= OWN_IDLE;
        end else begin
            r_own_state <= w_own_next;
        end
    end

    always_comb begin
        w_own_next = r_own_state;
        w_own_take = 1'b0;
        w_own_inc  = 1'b0;
        case (r_own_state)
            OWN_IDLE: begin
                if (w_low_found) begin
                    w_own_next = OWN_OWNED;
                    w_own_take = 1'b1;
                end
            end
            OWN_OWNED: begin
                if (btn_active[r_owner_id]) begin
                    w_own_inc = 1'b1;
                end else begin
                    w_own_next = OWN_IDLE;
                end
            end
            default: w_own_next = OWN_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_owner_id   <= '0;
            r_active_cnt <= '0;
        end else if (w_own_take) begin
            r_owner_id   <= w_low_idx;
            r_active_cnt <= '0;
        end else if (w_own_inc && (r_active_cnt != CNT_MAX)) begin
            r_active_cnt <= r_active_cnt + CNT_W'(1);
        end
    end

    // ---------------- outputs ----------------
    assign evt_valid   = !w_fifo_empty;
    assign evt_btn     = w_fifo_empty ? '0 : w_head[BTN_LSB +: IDW];
    assign evt_type    = !w_fifo_empty && w_head[TYPE_BIT];
    assign evt_time    = w_fifo_empty ? '0 : w_head[CNT_W-1:0];
    assign owner_valid = (r_own_state == OWN_OWNED);
    assign owner_id    = r_owner_id;
    assign active_cnt  = r_active_cnt;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_pbutton_event_arbiter.sv
// Bench for pbutton_event_arbiter: directed scenarios with literal expectations plus random
// traffic, all outputs compared every cycle against a queue-based behavioural model.
module tb_pbutton_event_arbiter;

    localparam int NB    = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 32;
    localparam int IDW   = 2;
    localparam longint unsigned TMAX = (64'd1 << CW) - 1;

    logic          CLOCK_50     = 1'b0;
    logic          RESET        = 1'b0;
    logic [NB-1:0] btn_active   = '0;
    logic [NB-1:0] btn_pushed   = '0;
    logic [NB-1:0] btn_released = '0;
    logic          evt_ready    = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          evt_valid;
    logic [IDW-1:0] evt_btn;
    logic          evt_type;
    logic [CW-1:0] evt_time;
    logic          owner_valid;
    logic [IDW-1:0] owner_id;
    logic [CW-1:0] active_cnt;
    logic          overflow;

    pbutton_event_arbiter #(
        .NB_BTN     (NB),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET        (RESET),
        .btn_active   (btn_active),
        .btn_pushed   (btn_pushed),
        .btn_released (btn_released),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_btn      (evt_btn),
        .evt_type     (evt_type),
        .evt_time     (evt_time),
        .owner_valid  (owner_valid),
        .owner_id     (owner_id),
        .active_cnt   (active_cnt),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int              btn;
        int              typ;
        longint unsigned t;
    } ev_t;

    ev_t             m_q[$];
    bit              m_pp [NB];
    bit              m_rp [NB];
    longint unsigned m_rt [NB];
    longint unsigned m_tm [NB];
    int              m_rr    = 0;
    bit              m_owned = 0;
    int              m_owner = 0;
    longint unsigned m_acnt  = 0;
    bit              m_ovf   = 0;

    task automatic model_step();
        bit  do_pop;
        bit  ovf_now;
        bit  found;
        int  gnt;
        ev_t e;
        if (RESET) begin
            m_q.delete();
            for (int i = 0; i < NB; i++) begin
                m_pp[i] = 0; m_rp[i] = 0; m_rt[i] = 0; m_tm[i] = 0;
            end
            m_rr = 0; m_owned = 0; m_owner = 0; m_acnt = 0; m_ovf = 0;
            return;
        end
        do_pop  = (m_q.size() > 0) && (evt_ready === 1'b1);
        gnt     = -1;
        ovf_now = 0;
        if (m_q.size() < DEPTH || do_pop) begin
            for (int k = 0; k < NB; k++) begin
                int b;
                b = (m_rr + k) % NB;
                if (gnt < 0 && (m_pp[b] || m_rp[b])) gnt = b;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (gnt >= 0) begin
            e.btn = gnt;
            if (m_pp[gnt]) begin
                e.typ = 1; e.t = 0; m_pp[gnt] = 0;
            end else begin
                e.typ = 0; e.t = m_rt[gnt]; m_rp[gnt] = 0;
            end
            m_q.push_back(e);
            m_rr = (gnt + 1) % NB;
        end
        for (int i = 0; i < NB; i++) begin
            if (btn_pushed[i]) begin
                if (m_pp[i]) ovf_now = 1; else m_pp[i] = 1;
            end
            if (btn_released[i]) begin
                if (m_rp[i]) ovf_now = 1;
                else begin m_rp[i] = 1; m_rt[i] = m_tm[i]; end
            end
            if (btn_pushed[i]) m_tm[i] = 0;
            else if (btn_active[i] && m_tm[i] < TMAX) m_tm[i]++;
        end
        if (!m_owned) begin
            found = 0;
            for (int i = 0; i < NB; i++) begin
                if (!found && btn_active[i]) begin found = 1; m_owner = i; end
            end
            if (found) begin m_owned = 1; m_acnt = 0; end
        end else if (btn_active[m_owner]) begin
            if (m_acnt < TMAX) m_acnt++;
        end else begin
            m_owned = 0;
        end
        if (ovf_now) m_ovf = 1;
        else if (clr_overflow) m_ovf = 0;
    endtask

    initial forever begin
        @(posedge CLOCK_50 or posedge RESET);
        model_step();
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge CLOCK_50);
        if (cmp_on) begin
            chk("evt_valid", 64'(evt_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("evt_btn", 64'(evt_btn), 64'(m_q[0].btn));
                chk("evt_type", 64'(evt_type), 64'(m_q[0].typ));
                chk("evt_time", 64'(evt_time), m_q[0].t);
            end
            chk("owner_valid", 64'(owner_valid), 64'(m_owned));
            if (m_owned) chk("owner_id", 64'(owner_id), 64'(m_owner));
            chk("active_cnt", 64'(active_cnt), m_acnt);
            chk("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    // ---------------- consumer log (popped events) ----------------
    typedef struct {
        int              btn;
        int              typ;
        longint unsigned t;
        int              cyc;
    } lg_t;

    lg_t dlog[$];

    initial forever begin
        lg_t l;
        @(negedge CLOCK_50);
        cyc++;
        if (!RESET && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            l.btn = int'(evt_btn);
            l.typ = int'(evt_type);
            l.t   = 64'(evt_time);
            l.cyc = cyc;
            dlog.push_back(l);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        for (int c = 0; c < budget && dlog.size() < n; c++) tick();
        chk(nm, 64'(dlog.size()), 64'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_b[9];
        int exp_t[9];
        int r;
        exp_b = '{2, 3, 0, 1, 2, 3, 0, 1, 0};
        exp_t = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

        #3 RESET = 1'b1;
        cmp_on = 1'b1;
        repeat (3) tick();
        chk("rst_evt_valid", 64'(evt_valid), 64'd0);
        chk("rst_evt_btn", 64'(evt_btn), 64'd0);
        chk("rst_evt_time", 64'(evt_time), 64'd0);
        chk("rst_owner_valid", 64'(owner_valid), 64'd0);
        chk("rst_active_cnt", 64'(active_cnt), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        RESET = 1'b0;
        tick();

        // 1: single press of btn1, 100 counted hold cycles
        evt_ready = 1'b1;
        dlog.delete();
        btn_active[1] = 1'b1; btn_pushed[1] = 1'b1; tick(); btn_pushed = '0;
        repeat (100) tick();
        btn_active[1] = 1'b0; btn_released[1] = 1'b1; tick(); btn_released = '0;
        wait_log(2, 20, "t1_count");
        if (dlog.size() >= 2) begin
            chk("t1_push_btn", 64'(dlog[0].btn), 64'd1);
            chk("t1_push_type", 64'(dlog[0].typ), 64'd1);
            chk("t1_push_time", dlog[0].t, 64'd0);
            chk("t1_rel_btn", 64'(dlog[1].btn), 64'd1);
            chk("t1_rel_type", 64'(dlog[1].typ), 64'd0);
            chk("t1_rel_time", dlog[1].t, 64'd100);
        end
        chk("t1_overflow", 64'(overflow), 64'd0);

        // 2: four simultaneous pushes, rr pointer at 2 after btn1's grant
        dlog.delete();
        btn_pushed = 4'b1111; tick(); btn_pushed = '0;
        wait_log(4, 20, "t2_count");
        for (int k = 0; k < 4 && k < dlog.size(); k++) begin
            chk("t2_order", 64'(dlog[k].btn), 64'(exp_b[k]));
            chk("t2_consec", 64'(dlog[k].cyc - dlog[0].cyc), 64'(k));
        end

        // 3: fill the FIFO, hold a ninth event, then overflow on a repeat pulse
        evt_ready = 1'b0;
        dlog.delete();
        btn_pushed = 4'b1111; tick(); btn_pushed = '0;
        repeat (6) tick();
        btn_released = 4'b1111; tick(); btn_released = '0;
        repeat (6) tick();
        btn_pushed = 4'b0001; tick(); btn_pushed = '0;
        repeat (3) tick();
        chk("t3_no_ovf_yet", 64'(overflow), 64'd0);
        btn_pushed = 4'b0001; tick(); btn_pushed = '0;
        chk("t3_ovf_set", 64'(overflow), 64'd1);
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        chk("t3_ovf_clr", 64'(overflow), 64'd0);
        btn_pushed = 4'b0001; clr_overflow = 1'b1; tick();
        btn_pushed = '0; clr_overflow = 1'b0;
        chk("t3_ovf_set_prio", 64'(overflow), 64'd1);
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        chk("t3_ovf_clr2", 64'(overflow), 64'd0);
        chk("t3_nothing_popped", 64'(dlog.size()), 64'd0);

        // 6: one pop while full lets the held event in on the same edge
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        repeat (3) tick();
        chk("t6_one_popped", 64'(dlog.size()), 64'd1);
        chk("t6_overflow", 64'(overflow), 64'd0);
        evt_ready = 1'b1;
        wait_log(9, 40, "t3_drain_count");
        for (int k = 0; k < 9 && k < dlog.size(); k++) begin
            chk("t3_drain_btn", 64'(dlog[k].btn), 64'(exp_b[k]));
            chk("t3_drain_type", 64'(dlog[k].typ), 64'(exp_t[k]));
            chk("t3_drain_time", dlog[k].t, 64'd0);
        end
        repeat (3) tick();

        // 4: ownership stays with btn2 while btn0 also presses
        for (int k = 0; k <= 40; k++) begin
            if (k == 0)  begin btn_active[2] = 1'b1; btn_pushed[2] = 1'b1; end
            if (k == 5)  begin btn_active[0] = 1'b1; btn_pushed[0] = 1'b1; end
            if (k == 15) begin btn_active[0] = 1'b0; btn_released[0] = 1'b1; end
            tick();
            btn_pushed = '0; btn_released = '0;
            if (k == 20) begin
                chk("t4_owner_valid", 64'(owner_valid), 64'd1);
                chk("t4_owner_id", 64'(owner_id), 64'd2);
            end
        end
        chk("t4_cnt40", 64'(active_cnt), 64'd40);
        btn_active[2] = 1'b0; btn_released[2] = 1'b1; tick(); btn_released = '0;
        chk("t4_drop", 64'(owner_valid), 64'd0);
        chk("t4_cnt_after_drop", 64'(active_cnt), 64'd40);
        repeat (3) tick();
        chk("t4_cnt_held", 64'(active_cnt), 64'd40);
        btn_active[0] = 1'b1; btn_pushed[0] = 1'b1; tick(); btn_pushed = '0;
        chk("t4_new_owner_valid", 64'(owner_valid), 64'd1);
        chk("t4_new_owner_id", 64'(owner_id), 64'd0);
        chk("t4_new_cnt0", 64'(active_cnt), 64'd0);
        repeat (3) tick();
        btn_active[0] = 1'b0; btn_released[0] = 1'b1; tick(); btn_released = '0;
        repeat (6) tick();

        // 5: reset in the middle of draining three queued events
        evt_ready = 1'b0;
        btn_active[3] = 1'b1;
        btn_pushed = 4'b1011; tick(); btn_pushed = '0;
        repeat (5) tick();
        chk("t5_queued", 64'(evt_valid), 64'd1);
        evt_ready = 1'b1; tick();
        #1 RESET = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(evt_valid), 64'd0);
        chk("t5_rst_cnt", 64'(active_cnt), 64'd0);
        chk("t5_rst_owner", 64'(owner_valid), 64'd0);
        tick();
        RESET = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t5_no_stale", 64'(evt_valid), 64'd0);
        end
        btn_active[3] = 1'b0; btn_released[3] = 1'b1; tick(); btn_released = '0;
        repeat (5) tick();

        // random traffic
        for (int c = 0; c < 2500; c++) begin
            btn_pushed = '0;
            btn_released = '0;
            for (int i = 0; i < NB; i++) begin
                r = $urandom_range(0, 99);
                if (!btn_active[i] && r < 10) begin
                    btn_active[i] = 1'b1; btn_pushed[i] = 1'b1;
                end else if (btn_active[i] && r < 8) begin
                    btn_active[i] = 1'b0; btn_released[i] = 1'b1;
                end else if (r == 99) begin
                    btn_pushed[i] = 1'b1;
                end else if (r == 98) begin
                    btn_released[i] = 1'b1;
                end
            end
            if ((c % 300) < 40) evt_ready = 1'b0;
            else evt_ready = ($urandom_range(0, 9) < 6);
            clr_overflow = ($urandom_range(0, 49) == 0);
            tick();
        end
        btn_pushed = '0; btn_released = '0; btn_active = '0;
        clr_overflow = 1'b0; evt_ready = 1'b1;
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
